intra4x4_mode_search: RTL
=========================

# intra4x4_mode_search

Sequencer for the 4x4 luma intra-prediction datapaths. On `start` it latches one original 4x4 block and issues the nine H.264 Intra_4x4 modes, one per cycle, to the shared prediction mux. It skips modes whose neighbours are unavailable, computes the SAD of each returned prediction against the original, and reports the lowest-cost mode. It sits between the macroblock control FSM and the per-mode predictors (the DDL, DDR and the other per-mode units), which register their outputs on `clk`.

## Interface
- PRED_LAT, 1: cycles from `pred_req`/`pred_mode` to a valid `pred_in`; legal range 1..4.
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a search; accepted only when `busy`=0
- orig_in  in  128  original block, pixel k (raster order a..p) in bits [8k+7:8k]; sampled on accepted `start`
- avail_top  in  1  row above (A..H, M) available; sampled on accepted `start`
- avail_left  in  1  column left (I..L, M) available; sampled on accepted `start`
- pred_req  out  1  prediction request for `pred_mode` this cycle
- pred_mode  out  4  mode index 0..8 being issued
- pred_in  in  128  predicted block, same packing as `orig_in`
- busy  out  1  search in progress
- done  out  1  one-cycle pulse; result valid
- best_mode  out  4  winning mode
- best_sad  out  12  winning SAD

## Operation
- Allowed modes:
  - 2 (DC): always allowed.
  - 0 (V), 3 (DDL), 7 (VL): need `avail_top`.
  - 1 (H), 8 (HU): need `avail_left`.
  - 4 (DDR), 5 (VR), 6 (HD): need both `avail_top` and `avail_left`.
- FSM:
  - IDLE: on `start`, latch `orig_in` and the availability flags, set internal best_sad=4095 and best_mode=2, go to ISSUE.
  - ISSUE: the mode counter m steps 0..8, one per cycle. `pred_mode`=m every cycle. `pred_req`=1 only when m is allowed. After m=8, go to DRAIN.
  - DRAIN: wait for the tag pipeline to empty, pulse `done`, go to IDLE.
- Tag pipeline: a {valid, mode} shift register PRED_LAT deep. The valid bit equals `pred_req`.
  - When a tag exits, compute SAD = sum of |orig_k - pred_k| over k=0..15. Use 9-bit signed differences and a 12-bit unsigned sum (max 4080, no overflow).
  - Register the SAD with its tag (stage S).
- Compare at stage S: replace best only if sad < best_sad (strict). Ties keep the earlier, lower-index mode.
- `best_mode`/`best_sad` update during a search. They are meaningful only from the `done` cycle and hold until the next accepted `start`.
- `start` while `busy`=1 is ignored, with no effect on the current search.
- `pred_in` is ignored in any cycle without an exiting valid tag.

## Timing
- Accepted `start` at cycle 0:
  - mode m issued in cycle 1+m
  - its `pred_in` is sampled in cycle 1+m+PRED_LAT
  - its SAD is registered at the end of that cycle
  - best is updated at the end of cycle 2+m+PRED_LAT
- `done`=1 in cycle 11+PRED_LAT (12 for default). The result is visible on `best_*` that cycle.
- `busy`=1 from cycle 1 through the `done` cycle inclusive. A new `start` is accepted in the cycle after `done`.
- Latency is fixed and independent of availability, because skipped modes still consume their issue slot.
- Reset values: `pred_req`=0, `pred_mode`=0, `busy`=0, `done`=0, `best_mode`=0, `best_sad`=0. State IDLE, tag pipeline cleared.
- Reset mid-search: abort on the next edge. No `done` is produced. Outputs return to reset values.
- `start` and `reset` together: reset wins.

## Test plan
- Both flags=1. Bench predictor returns `orig_in` for mode 4 and orig+1 per pixel for all other modes. Required: `pred_req` in cycles 1..9, `done` in cycle 12, best_mode=4, best_sad=0.
- Both flags=0. Required: `pred_req` only in cycle 3 with `pred_mode`=2. DC prediction all 128 vs orig all 0 gives best_mode=2, best_sad=2048.
- Tie case: top only. Modes 0, 3 and 7 each return SAD 16, DC returns SAD 32. Required: best_mode=0, best_sad=16.
- Max cost: orig all 255, every allowed prediction all 0. Required: best_sad=4080 with no wrap; best_mode=0 (lowest allowed index wins on ties).
- `start` pulsed in cycle 5 of a search. Required: ignored, `done` still in cycle 12 only, result unchanged.
- `reset` asserted in cycle 7. Required: all outputs at reset values from cycle 8, no `done`. A following `start` completes normally. With PRED_LAT=3, `done` moves to cycle 14.

Source files
------------

// File: rtl/intra4x4_mode_search.sv
`default_nettype none
// ============================================================================
// Module      : intra4x4_mode_search
// Description : Sequencer for the 4x4 luma intra-prediction datapaths.
//               On start, latches one original 4x4 block and the neighbour
//               availability flags. It then issues the nine Intra_4x4 modes,
//               one per cycle, and skips modes whose neighbours are missing.
//               It computes the SAD of every returned prediction and reports
//               the lowest-cost mode.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               start             - begin a search (accepted when idle)
//               orig_in           - original block, pixel k in [8k+7:8k]
//               avail_top/left    - neighbour availability, sampled on start
//               pred_req/pred_mode- request to the shared prediction mux
//               pred_in           - prediction, PRED_LAT cycles after request
//               busy, done        - search in progress / one-cycle result pulse
//               best_mode/best_sad- lowest-cost mode and its SAD
// Revision    : 1.0 - initial release
// ============================================================================
module intra4x4_mode_search #(
    parameter int PRED_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] orig_in,
    input  logic         avail_top,
    input  logic         avail_left,
    output logic         pred_req,
    output logic [3:0]   pred_mode,
    input  logic [127:0] pred_in,
    output logic         busy,
    output logic         done,
    output logic [3:0]   best_mode,
    output logic [11:0]  best_sad
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_issue  = 2'd1;
    localparam logic [1:0]  c_st_drain  = 2'd2;
    localparam logic [3:0]  c_last_mode = 4'd8;
    localparam logic [3:0]  c_mode_dc   = 4'd2;
    localparam logic [11:0] c_sad_init  = 12'd4095;
    // The drain counter runs until the last tag has gone through the
    // predictor latency, the SAD stage and the compare stage.
    localparam logic [3:0]  c_drain_end = 4'(PRED_LAT + 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                w_start_ok;
    logic                w_allowed;
    logic [127:0]        r_orig;
    logic                r_top;
    logic                r_left;
    logic [PRED_LAT-1:0] r_tag_v;
    logic [3:0]          r_tag_m [PRED_LAT];
    logic [11:0]         w_sad;
    logic                r_s_v;
    logic [3:0]          r_s_mode;
    logic [11:0]         r_s_sad;
    logic [3:0]          r_best_mode;
    logic [11:0]         r_best_sad;

    function automatic logic [7:0] f_abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[8] ? 8'(-d) : d[7:0];
    endfunction

    // Mode availability against the latched neighbour flags.
    always_comb begin
        w_allowed = 1'b0;
        case (r_cnt)
            4'd0, 4'd3, 4'd7: w_allowed = r_top;
            4'd1, 4'd8:       w_allowed = r_left;
            4'd4, 4'd5, 4'd6: w_allowed = r_top & r_left;
            4'd2:             w_allowed = 1'b1;
            default:          w_allowed = 1'b0;
        endcase
    end

    // Next-state logic and outputs. Skipped modes still use their issue
    // slot, so the latency does not depend on availability.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start_ok  = 1'b0;
        pred_req    = 1'b0;
        pred_mode   = 4'd0;
        done        = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = c_st_issue;
                    w_cnt_nxt   = 4'd0;
                end
            end
            c_st_issue: begin
                pred_mode = r_cnt;
                pred_req  = w_allowed;
                if (r_cnt == c_last_mode) begin
                    w_state_nxt = c_st_drain;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            c_st_drain: begin
                if (r_cnt == c_drain_end) begin
                    done        = 1'b1;
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // SAD of the prediction that the predictors return this cycle.
    always_comb begin
        w_sad = 12'd0;
        for (int k = 0; k < 16; k++) begin
            w_sad = w_sad + 12'(f_abs_diff(r_orig[8*k +: 8], pred_in[8*k +: 8]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= 4'd0;
            r_orig      <= '0;
            r_top       <= 1'b0;
            r_left      <= 1'b0;
            r_tag_v     <= '0;
            for (int i = 0; i < PRED_LAT; i++) begin
                r_tag_m[i] <= 4'd0;
            end
            r_s_v       <= 1'b0;
            r_s_mode    <= 4'd0;
            r_s_sad     <= 12'd0;
            r_best_mode <= 4'd0;
            r_best_sad  <= 12'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;

            // Tag pipeline mirrors the predictor latency.
            r_tag_v[0] <= pred_req;
            r_tag_m[0] <= pred_mode;
            for (int i = 1; i < PRED_LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_m[i] <= r_tag_m[i-1];
            end

            // Stage S: the SAD is registered with its exiting tag.
            r_s_v <= r_tag_v[PRED_LAT-1];
            if (r_tag_v[PRED_LAT-1]) begin
                r_s_mode <= r_tag_m[PRED_LAT-1];
                r_s_sad  <= w_sad;
            end

            if (w_start_ok) begin
                r_orig      <= orig_in;
                r_top       <= avail_top;
                r_left      <= avail_left;
                r_best_mode <= c_mode_dc;
                r_best_sad  <= c_sad_init;
            end else if (r_s_v && (r_s_sad < r_best_sad)) begin
                // A strict compare keeps the earlier, lower-index mode on ties.
                r_best_mode <= r_s_mode;
                r_best_sad  <= r_s_sad;
            end
        end
    end

    assign busy      = (r_state != c_st_idle);
    assign best_mode = r_best_mode;
    assign best_sad  = r_best_sad;

endmodule
`default_nettype wire
